bash_hash_ctrl: RTL and testbench

Job sequencer that drives the `bash_hash` round core, the initiator side of the core's `prep_i`/`start_i`/`work_i`/`l_i`/`x*_i`/`y*_o` interface.
- Input side: accepts a 16-word message block over a valid/ready word stream.
- Core side: pulses the core start strobe, runs the 23 work cycles, and captures the 8-word result.
- Output side: streams the result out over a second valid/ready port.
- Placement: sits between the host bus adapter and the core inside `bash_hash_top`.

---
 rtl/bash_hash_params_pkg.sv | 17 +
 rtl/bash_ctrl_oser.sv | 56 +++++
 rtl/bash_hash_ctrl.sv | 139 +++++++++++++
 tb/tb_bash_hash_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bash_hash_params_pkg.sv
// rtl/bash_hash_params_pkg.sv - shared bash_hash word sizes, round count and controller state type
package bash_hash_params_pkg;

  localparam int SLEN           = 64;
  localparam int BASH_ROUNDS    = 24;
  localparam int BASH_IN_WORDS  = 16;
  localparam int BASH_OUT_WORDS = 8;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_START,
    ST_ROUND,
    ST_CAPTURE,
    ST_DRAIN
  } bash_ctrl_state_t;

endpackage

// File: rtl/bash_ctrl_oser.sv
// rtl/bash_ctrl_oser.sv - 8-word load-parallel, shift-out result serializer with valid/ready/last
module bash_ctrl_oser #(
  parameter int SLEN = 64,
  parameter int NW   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_i,
  input  logic [NW-1:0][SLEN-1:0]  par_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [SLEN-1:0]          out_data_o,
  output logic                     out_last_o,
  output logic                     done_o
);

  localparam int CW = $clog2(NW);

  logic [NW-1:0][SLEN-1:0] sreg;
  logic [CW-1:0]           ocnt;
  logic                    valid_q;
  logic                    fire;

  // Valid is forced low during reset so nothing escapes from an abandoned job.
  assign out_valid_o = valid_q && !rst_i;
  assign fire        = out_valid_o && out_ready_i;
  assign out_last_o  = out_valid_o && (ocnt == CW'(NW - 1));
  assign out_data_o  = out_valid_o ? sreg[0] : '0;
  assign done_o      = fire && out_last_o;

  // Word counter and valid flag: armed by load, cleared by the last handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ocnt    <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ocnt    <= '0;
    end else if (fire) begin
      ocnt <= ocnt + 1'b1;
      if (ocnt == CW'(NW - 1)) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Data shifts toward slot 0 on each handshake; contents are only visible while valid.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      sreg <= par_i;
    end else if (fire) begin
      sreg <= {SLEN'(0), sreg[NW-1:1]};
    end
  end

endmodule

// File: rtl/bash_hash_ctrl.sv
// rtl/bash_hash_ctrl.sv - job sequencer feeding the bash_hash round core and serializing its result
module bash_hash_ctrl #(
  parameter int SLEN        = bash_hash_params_pkg::SLEN,
  parameter int BASH_ROUNDS = bash_hash_params_pkg::BASH_ROUNDS
) (
  input  logic                                                clk_i,
  input  logic                                                rst_i,
  input  logic                                                in_valid_i,
  output logic                                                in_ready_o,
  input  logic [SLEN-1:0]                                     in_data_i,
  input  logic [1:0]                                          lvl_i,
  input  logic                                                prep_i,
  output logic                                                out_valid_o,
  input  logic                                                out_ready_i,
  output logic [SLEN-1:0]                                     out_data_o,
  output logic                                                out_last_o,
  output logic                                                busy_o,
  output logic                                                core_prep_o,
  output logic                                                core_start_o,
  output logic                                                core_work_o,
  output logic [1:0]                                          core_l_o,
  output logic [bash_hash_params_pkg::BASH_IN_WORDS-1:0][SLEN-1:0]  core_x_o,
  input  logic [bash_hash_params_pkg::BASH_OUT_WORDS-1:0][SLEN-1:0] core_y_i
);

  import bash_hash_params_pkg::*;

  localparam int RW = $clog2(BASH_ROUNDS);

  bash_ctrl_state_t                   state_q, state_n;
  logic [3:0]                         wcnt;
  logic [RW-1:0]                      rcnt;
  logic [1:0]                         lvl_q, l_hold;
  logic                               prep_q;
  logic [BASH_IN_WORDS-1:0][SLEN-1:0] xbuf, x_hold;
  logic                               in_fire;
  logic                               cap;
  logic                               drain_done;

  assign in_ready_o = (state_q == ST_LOAD) && !rst_i;
  assign in_fire    = in_valid_i && in_ready_o;
  assign busy_o     = !rst_i && ((state_q != ST_LOAD) || (wcnt != 4'd0));

  // The core sees the live buffer in START, then a held copy so the next LOAD cannot disturb it.
  assign core_x_o = (state_q == ST_START) ? xbuf  : x_hold;
  assign core_l_o = (state_q == ST_START) ? lvl_q : l_hold;

  // State register and work-cycle counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_LOAD;
      rcnt    <= '0;
    end else begin
      state_q <= state_n;
      if (state_q == ST_START) begin
        rcnt <= '0;
      end else if (state_q == ST_ROUND) begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end

  // Input word counter; wraps to zero on the 16th word, ready for the next job.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wcnt <= '0;
    end else if (in_fire) begin
      wcnt <= wcnt + 1'b1;
    end
  end

  // Message buffer, job parameters from word 0, and the core-side hold copy taken in START.
  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      xbuf[wcnt] <= in_data_i;
      if (wcnt == 4'd0) begin
        lvl_q  <= lvl_i;
        prep_q <= prep_i;
      end
    end
    if (state_q == ST_START && !rst_i) begin
      x_hold <= xbuf;
      l_hold <= lvl_q;
    end
  end

  // Next state and core strobes; reset silences every strobe in the same cycle.
  always_comb begin
    state_n      = state_q;
    core_start_o = 1'b0;
    core_prep_o  = 1'b0;
    core_work_o  = 1'b0;
    cap          = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (in_fire && wcnt == 4'(BASH_IN_WORDS - 1)) state_n = ST_START;
      end
      ST_START: begin
        core_start_o = 1'b1;
        core_prep_o  = prep_q;
        state_n      = ST_ROUND;
      end
      ST_ROUND: begin
        core_work_o = 1'b1;
        if (rcnt == RW'(BASH_ROUNDS - 2)) state_n = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        cap     = 1'b1;
        state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_done) state_n = ST_LOAD;
      end
      default: state_n = ST_LOAD;
    endcase
    if (rst_i) begin
      core_start_o = 1'b0;
      core_prep_o  = 1'b0;
      core_work_o  = 1'b0;
      cap          = 1'b0;
    end
  end

  bash_ctrl_oser #(
    .SLEN (SLEN),
    .NW   (BASH_OUT_WORDS)
  ) u_oser (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (cap),
    .par_i       (core_y_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .done_o      (drain_done)
  );

endmodule

// File: tb/tb_bash_hash_ctrl.sv
// tb/tb_bash_hash_ctrl.sv - directed self-checking bench for bash_hash_ctrl with a stand-in core
module tb_bash_hash_ctrl;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [63:0]       in_data = '0;
  logic [1:0]        lvl = '0;
  logic              prep = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [63:0]       out_data;
  logic              out_last;
  logic              busy;
  logic              core_prep, core_start, core_work;
  logic [1:0]        core_l;
  logic [15:0][63:0] core_x;
  logic [7:0][63:0]  core_y;

  bash_hash_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .lvl_i(lvl), .prep_i(prep),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last),
    .busy_o(busy),
    .core_prep_o(core_prep), .core_start_o(core_start), .core_work_o(core_work),
    .core_l_o(core_l), .core_x_o(core_x), .core_y_i(core_y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in core: latches inputs on start, counts work cycles, result mixes both.
  logic [15:0][63:0] fx;
  logic [1:0]        fl;
  logic              fp;
  int                fw;
  always @(posedge clk) begin
    if (core_start === 1'b1) begin
      fx <= core_x; fl <= core_l; fp <= core_prep; fw <= 0;
    end else if (core_work === 1'b1) begin
      fw <= fw + 1;
    end
  end
  always_comb begin
    core_y = '0;
    for (int i = 0; i < 8; i++)
      core_y[i] = fx[2*i] ^ {fx[2*i+1][62:0], fx[2*i+1][63]} ^ {fl, fp, 61'(fw)};
  end

  // Monitor of core strobes and input handshakes.
  int start_n = 0, prep_n = 0, work_n = 0, in_hs = 0, start_cyc = 0;
  int ovl_err = 0, prep_err = 0, hold_err = 0;
  bit seen_start = 0;
  logic [15:0][63:0] x_snap;
  logic [1:0]        l_snap;
  always @(negedge clk) begin
    if (core_start === 1'b1) begin
      start_n++; start_cyc = cyc; x_snap = core_x; l_snap = core_l; seen_start = 1;
    end else if (seen_start && (core_x !== x_snap || core_l !== l_snap)) begin
      hold_err++;
    end
    if (core_prep === 1'b1) prep_n++;
    if (core_prep === 1'b1 && core_start !== 1'b1) prep_err++;
    if (core_work === 1'b1) work_n++;
    if (core_start === 1'b1 && core_work === 1'b1) ovl_err++;
    if (in_valid === 1'b1 && in_ready === 1'b1) in_hs++;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [63:0] seed;
    logic [63:0] step;
    logic [1:0]  lvl;
    logic        prep;
    bit          gap;
    bit          bp;
  } job_t;

  logic [63:0] w [16];
  logic [63:0] exp_y [8];
  logic [1:0]  cur_lvl;
  logic        cur_prep;
  int s_start, s_prep, s_work, s_hs;

  task automatic set_job(input logic [63:0] seed, input logic [63:0] step, input logic [1:0] l, input logic p);
    logic [63:0] tag;
    for (int k = 0; k < 16; k++) w[k] = seed + 64'(k) * step;
    cur_lvl = l; cur_prep = p;
    tag = {l, p, 61'd23};
    for (int i = 0; i < 8; i++) exp_y[i] = w[2*i] ^ {w[2*i+1][62:0], w[2*i+1][63]} ^ tag;
  endtask

  task automatic snap();
    s_start = start_n; s_prep = prep_n; s_work = work_n; s_hs = in_hs;
  endtask

  task automatic send_word(input logic [63:0] d, output int hcyc, output int waits);
    in_data = d; lvl = cur_lvl; prep = cur_prep; in_valid = 1'b1;
    waits = 0; hcyc = -1;
    while (waits < 200) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin hcyc = cyc; break; end
      waits++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (hcyc < 0) chk("in_timeout", 64'(waits), 64'd0);
  endtask

  task automatic do_load(input int k0, input bit gap, output int hs);
    int wt;
    hs = -1;
    for (int k = k0; k < 16; k++) begin
      send_word(w[k], hs, wt);
      if (gap && k < 15) begin @(posedge clk); #1; end
    end
  endtask

  task automatic do_recv(input string nm, input bit bp, output int fc);
    int v = 0, got = 0, t = 0, last_err = 0, stab_err = 0;
    bit stalled = 0;
    logic [63:0] held;
    logic held_last;
    fc = -1;
    out_ready = 1'b0;
    while (got < 8 && t < 400) begin
      @(negedge clk); t++;
      if (out_valid === 1'b1) begin
        if (fc < 0) fc = cyc;
        if (stalled && (out_data !== held || out_last !== held_last)) stab_err++;
        out_ready = bp ? (v >= 5 && (v % 2) == 1) : 1'b1;
        v++;
        if (out_ready) begin
          chk($sformatf("%s_y%0d", nm, got), out_data, exp_y[got]);
          if (out_last !== (got == 7)) last_err++;
          got++; stalled = 0;
        end else begin
          stalled = 1; held = out_data; held_last = out_last;
        end
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_handshakes"}, 64'(got), 64'd8);
    chk({nm, "_last_err"}, 64'(last_err), 64'd0);
    chk({nm, "_stall_err"}, 64'(stab_err), 64'd0);
  endtask

  task automatic core_checks(input string nm, input int hs, input int fc);
    chk({nm, "_start_cycles"}, 64'(start_n - s_start), 64'd1);
    chk({nm, "_prep_cycles"}, 64'(prep_n - s_prep), 64'(cur_prep));
    chk({nm, "_work_cycles"}, 64'(work_n - s_work), 64'd23);
    chk({nm, "_start_lat"}, 64'(start_cyc - hs), 64'd1);
    chk({nm, "_valid_lat"}, 64'(fc - hs), 64'd26);
    chk({nm, "_in_handshakes"}, 64'(in_hs - s_hs), 64'd16);
    chk({nm, "_core_l"}, 64'(l_snap), 64'(cur_lvl));
    for (int k = 0; k < 16; k++) chk($sformatf("%s_x%0d", nm, k), x_snap[k], w[k]);
  endtask

  task automatic run_job(input string nm, input bit gap, input bit bp, input bit hold_next,
                         input logic [63:0] next_w0);
    int hs, fc, ih;
    snap();
    do_load(0, gap, hs);
    if (hold_next) begin in_valid = 1'b1; in_data = next_w0; end
    ih = in_hs;
    do_recv(nm, bp, fc);
    if (hold_next) chk({nm, "_ignored_words"}, 64'(in_hs - ih), 64'd0);
    core_checks(nm, hs, fc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    job_t jobs [4];
    int hs, fc, wt;
    logic [63:0] b_seed, b_step;
    jobs[0] = '{"basic",   64'h1,                64'h1,                2'b11, 1'b1, 1'b0, 1'b0};
    jobs[1] = '{"gaps",    64'h1,                64'h1,                2'b11, 1'b1, 1'b1, 1'b0};
    jobs[2] = '{"backpr",  64'hA5A5_5A5A_0F0F_F0F0, 64'h9E37_79B9_7F4A_7C15, 2'b01, 1'b1, 1'b0, 1'b1};
    jobs[3] = '{"noprep",  64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 2'b10, 1'b0, 1'b1, 1'b1};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_strobes", 64'({core_start, core_work, core_prep}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    for (int j = 0; j < 4; j++) begin
      set_job(jobs[j].seed, jobs[j].step, jobs[j].lvl, jobs[j].prep);
      run_job(jobs[j].name, jobs[j].gap, jobs[j].bp, 1'b0, 64'd0);
    end

    // Reset pulsed while the round counter is at 10.
    set_job(64'hDEAD_BEEF_0000_0001, 64'h0101_0101_0101_0101, 2'b00, 1'b1);
    snap();
    do_load(0, 1'b0, hs);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mid_work_before", 64'(core_work), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_work_in_rst", 64'(core_work), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_work_after", 64'(core_work), 64'd0);
    chk("mid_in_ready", 64'(in_ready), 64'd1);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    run_job("after_rst", 1'b0, 1'b0, 1'b0, 64'd0);

    // in_valid held through DRAIN, then next job's word 0 taken the very next cycle.
    b_seed = 64'h7777_0000_1234_5678;
    b_step = 64'h0F0F_0F0F_0000_0001;
    set_job(64'h4242_4242_4242_4242, 64'h3, 2'b10, 1'b1);
    run_job("b2b_a", 1'b0, 1'b0, 1'b1, b_seed);
    set_job(b_seed, b_step, 2'b10, 1'b1);
    snap();
    send_word(w[0], hs, wt);
    chk("b2b_word0_wait", 64'(wt), 64'd0);
    do_load(1, 1'b0, hs);
    do_recv("b2b_b", 1'b0, fc);
    core_checks("b2b_b", hs, fc);

    chk("start_work_overlap", 64'(ovl_err), 64'd0);
    chk("prep_outside_start", 64'(prep_err), 64'd0);
    chk("core_x_hold", 64'(hold_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
